// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low codes, segment bit indices, output FSM states.
package seg7_pkg;

  // Segment bit positions on the active-low bus
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low patterns for hex digits 0..F, and the all-off pattern
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_HA    = 7'h08;
  localparam logic [6:0] SEG_HB    = 7'h03;
  localparam logic [6:0] SEG_HC    = 7'h46;
  localparam logic [6:0] SEG_HD    = 7'h21;
  localparam logic [6:0] SEG_HE    = 7'h06;
  localparam logic [6:0] SEG_HF    = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Output slot state
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern to a hex digit.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_legal,
  output logic       is_blank
);

  // Reverse lookup of the encoder table; anything unlisted is illegal
  always_comb begin
    digit    = '0;
    is_legal = 1'b1;
    is_blank = (pattern == SEG_BLANK);
    unique case (pattern)
      SEG_0:   digit = 4'h0;
      SEG_1:   digit = 4'h1;
      SEG_2:   digit = 4'h2;
      SEG_3:   digit = 4'h3;
      SEG_4:   digit = 4'h4;
      SEG_5:   digit = 4'h5;
      SEG_6:   digit = 4'h6;
      SEG_7:   digit = 4'h7;
      SEG_8:   digit = 4'h8;
      SEG_9:   digit = 4'h9;
      SEG_HA:  digit = 4'hA;
      SEG_HB:  digit = 4'hB;
      SEG_HC:  digit = 4'hC;
      SEG_HD:  digit = 4'hD;
      SEG_HE:  digit = 4'hE;
      SEG_HF:  digit = 4'hF;
      default: is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Debounced 7-segment bus readback: decodes newly stable patterns into a
// single-slot valid/ready digit stream with error, blank and overrun flags.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       SEG,
  output logic [3:0]       OUT_DIGIT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR,
  output logic             BLANK,
  output logic             OVERRUN,
  output logic [CNT_W-1:0] CHG_CNT
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACCEPT_AT  = 8'(STABLE_CYCLES - 1);

  logic [6:0] s_q;
  logic [7:0] stab_cnt;
  logic [6:0] last_acc;
  logic       have_acc;

  logic [3:0] dec_digit;
  logic       dec_legal;
  logic       dec_blank;

  logic       accept;
  logic       digit_evt;

  out_state_t state, state_d;
  logic       load;
  logic       drop;

  seg7_pattern_decode u_decode (
    .pattern  (s_q),
    .digit    (dec_digit),
    .is_legal (dec_legal),
    .is_blank (dec_blank)
  );

  // The counter steps S-1 -> S exactly once per stable run, so acceptance
  // fires once; the new-pattern test suppresses re-emission after glitches.
  assign accept    = (SEG == s_q) && (stab_cnt == ACCEPT_AT) &&
                     (!have_acc || (s_q != last_acc));
  assign digit_evt = accept && dec_legal;

  // Sample the bus, run the stability counter and record accepted patterns
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= SEG_BLANK;
      stab_cnt <= '0;
      last_acc <= SEG_BLANK;
      have_acc <= 1'b0;
      ERR      <= 1'b0;
      BLANK    <= 1'b0;
    end else begin
      s_q <= SEG;
      if (SEG != s_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STABLE_MAX) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
      if (accept) begin
        last_acc <= s_q;
        have_acc <= 1'b1;
        ERR      <= !dec_legal && !dec_blank;
        BLANK    <= dec_blank;
      end
    end
  end

  // Output slot state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Slot next-state: load on event when free or being drained, drop otherwise
  always_comb begin
    state_d = state;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (digit_evt) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (OUT_READY) begin
          if (digit_evt) begin
            load = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (digit_evt) begin
          drop = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Digit slot, event counter and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_DIGIT <= '0;
      CHG_CNT   <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      if (load) begin
        OUT_DIGIT <= dec_digit;
        CHG_CNT   <= CHG_CNT + CNT_W'(1);
      end
      if (drop) begin
        OVERRUN <= 1'b1;
      end
    end
  end

  assign OUT_VALID = (state == ST_FULL);

endmodule

// File: tb/tb_seg7_readback.sv
// Directed self-checking bench for seg7_readback (STABLE_CYCLES=4, CNT_W=8).
module tb_seg7_readback;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] SEG;
  logic [3:0] OUT_DIGIT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       ERR;
  logic       BLANK;
  logic       OVERRUN;
  logic [7:0] CHG_CNT;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  seg7_readback #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .SEG       (SEG),
    .OUT_DIGIT (OUT_DIGIT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ERR       (ERR),
    .BLANK     (BLANK),
    .OVERRUN   (OVERRUN),
    .CHG_CNT   (CHG_CNT)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    SEG = 7'h7F;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    OUT_READY = 1'b1;
    do_reset();
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'd0) $display("FAIL reset_valid_digit got=%h exp=0", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    n_total++; if ({ERR, BLANK, OVERRUN} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {ERR, BLANK, OVERRUN}); else n_pass++;
    n_total++; if (CHG_CNT !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", CHG_CNT); else n_pass++;
  endtask

  task automatic test_first_digit();
    do_reset();
    OUT_READY = 1'b1;
    SEG = 7'h24;
    step(4);
    n_total++; if (OUT_VALID !== 1'b0) $display("FAIL first_early got=%b exp=0", OUT_VALID); else n_pass++;
    step(1);
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'h12) $display("FAIL first_digit got=%h exp=12", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    n_total++; if ({CHG_CNT, ERR, BLANK} !== {8'd1, 2'b00}) $display("FAIL first_cnt_flags got=%h exp=%h", {CHG_CNT, ERR, BLANK}, {8'd1, 2'b00}); else n_pass++;
    step(1);
    n_total++; if (OUT_VALID !== 1'b0) $display("FAIL first_drain got=%b exp=0", OUT_VALID); else n_pass++;
  endtask

  task automatic test_glitch();
    int unsigned seen = 0;
    do_reset();
    OUT_READY = 1'b1;
    SEG = 7'h79;
    step(5);
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'h11) $display("FAIL glitch_first got=%h exp=11", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    SEG = 7'h24;
    step(3);
    SEG = 7'h79;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (OUT_VALID === 1'b1) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL glitch_events got=%0d exp=0", seen); else n_pass++;
    n_total++; if (CHG_CNT !== 8'd1) $display("FAIL glitch_cnt got=%0d exp=1", CHG_CNT); else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    OUT_READY = 1'b0;
    SEG = 7'h0E;
    step(6);
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'h1F) $display("FAIL ovr_first got=%h exp=1f", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    SEG = 7'h46;
    step(6);
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'h1F) $display("FAIL ovr_hold got=%h exp=1f", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    n_total++; if ({OVERRUN, CHG_CNT} !== {1'b1, 8'd1}) $display("FAIL ovr_flag_cnt got=%h exp=%h", {OVERRUN, CHG_CNT}, {1'b1, 8'd1}); else n_pass++;
    OUT_READY = 1'b1;
    step(1);
    n_total++; if ({OUT_VALID, OVERRUN} !== 2'b01) $display("FAIL ovr_drain got=%b exp=01", {OUT_VALID, OVERRUN}); else n_pass++;
  endtask

  task automatic test_blank_illegal();
    do_reset();
    OUT_READY = 1'b1;
    SEG = 7'h7F;
    step(6);
    n_total++; if ({BLANK, ERR, OUT_VALID, CHG_CNT} !== {3'b100, 8'd0}) $display("FAIL blank got=%h exp=%h", {BLANK, ERR, OUT_VALID, CHG_CNT}, {3'b100, 8'd0}); else n_pass++;
    SEG = 7'h55;
    step(6);
    n_total++; if ({BLANK, ERR, OUT_VALID, CHG_CNT} !== {3'b010, 8'd0}) $display("FAIL illegal got=%h exp=%h", {BLANK, ERR, OUT_VALID, CHG_CNT}, {3'b010, 8'd0}); else n_pass++;
    SEG = 7'h00;
    step(5);
    n_total++; if ({OUT_VALID, OUT_DIGIT, ERR, BLANK} !== 7'b1100000) $display("FAIL legal_after_err got=%b exp=1100000", {OUT_VALID, OUT_DIGIT, ERR, BLANK}); else n_pass++;
    n_total++; if (CHG_CNT !== 8'd1) $display("FAIL legal_after_err_cnt got=%0d exp=1", CHG_CNT); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    OUT_READY = 1'b0;
    SEG = 7'h30;
    step(5);
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'h13) $display("FAIL b2b_first got=%h exp=13", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    SEG = 7'h19;
    step(4);
    OUT_READY = 1'b1;
    step(1);
    n_total++; if ({OUT_VALID, OUT_DIGIT} !== 5'h14) $display("FAIL b2b_reload got=%h exp=14", {OUT_VALID, OUT_DIGIT}); else n_pass++;
    n_total++; if ({OVERRUN, CHG_CNT} !== {1'b0, 8'd2}) $display("FAIL b2b_cnt got=%h exp=%h", {OVERRUN, CHG_CNT}, {1'b0, 8'd2}); else n_pass++;
    step(1);
    n_total++; if (OUT_VALID !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", OUT_VALID); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    OUT_READY = 1'b0;
    SEG = 7'h40;
    step(5);
    SEG = 7'h12;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_total++; if ({OUT_VALID, OUT_DIGIT, ERR, BLANK, OVERRUN, CHG_CNT} !== 16'd0) $display("FAIL midrst_outputs got=%h exp=0", {OUT_VALID, OUT_DIGIT, ERR, BLANK, OVERRUN, CHG_CNT}); else n_pass++;
    step(4);
    n_total++; if (OUT_VALID !== 1'b0) $display("FAIL midrst_early got=%b exp=0", OUT_VALID); else n_pass++;
    step(1);
    n_total++; if ({OUT_VALID, OUT_DIGIT, CHG_CNT} !== {5'h15, 8'd1}) $display("FAIL midrst_reaccept got=%h exp=%h", {OUT_VALID, OUT_DIGIT, CHG_CNT}, {5'h15, 8'd1}); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 256; i++) begin
      SEG = (i % 2 == 0) ? 7'h79 : 7'h24;
      step(5);
      if (i == 254) begin
        n_total++; if (CHG_CNT !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", CHG_CNT); else n_pass++;
      end
    end
    n_total++; if ({CHG_CNT, OUT_DIGIT, OVERRUN} !== {8'd0, 4'h2, 1'b0}) $display("FAIL wrap_zero got=%h exp=%h", {CHG_CNT, OUT_DIGIT, OVERRUN}, {8'd0, 4'h2, 1'b0}); else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    SEG       = 7'h7F;
    OUT_READY = 1'b0;
    test_reset();
    test_first_digit();
    test_glitch();
    test_overrun();
    test_blank_illegal();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder.
- Samples an active-low 7-segment bus (bit0=a … bit6=g) and debounces it with a stability filter.
- Decodes each newly stable pattern back to a 4-bit hex digit and delivers it through a valid/ready handshake.
- Used for board self-test loopback and for monitoring segment buses driven by other logic; flags illegal patterns, blank displays and overruns.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 1..255.
- CNT_W, 8, width of the accepted-digit event counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- SEG  input  7  active-low segment bus, bit0=a … bit6=g; asynchronous to the decoder's notion of stability, synchronous to clk.
- OUT_DIGIT  output  4  decoded hex digit.
- OUT_VALID  output  1  OUT_DIGIT holds an undelivered event.
- OUT_READY  input  1  consumer accepts the event when high together with OUT_VALID.
- ERR  output  1  last accepted pattern was illegal (level).
- BLANK  output  1  last accepted pattern was all-off, 7'h7F (level).
- OVERRUN  output  1  sticky; an event was dropped because the slot was full.
- CHG_CNT  output  CNT_W  count of legal digit events emitted; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: OUT_DIGIT=0, OUT_VALID=0, ERR=0, BLANK=0, OVERRUN=0, CHG_CNT=0. The sample register is set to 7'h7F and the stability counter to 0. The "have-accepted" flag is cleared, so the first stable pattern after reset is always accepted, including blank.
- Legal patterns (hex, digit:code): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E. Blank is 7F. Every other code is illegal.
- Sampling: SEG is captured into s_q every edge.
  - If the captured value differs from the previous s_q, the stability counter resets to 0.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- Acceptance: occurs on the edge where the counter reaches STABLE_CYCLES-1→STABLE_CYCLES. The pattern must differ from the last accepted pattern, or no pattern has been accepted since reset.
  - Latency: SEG held constant from before edge n → acceptance effect visible after edge n+STABLE_CYCLES.
  - A glitch lasting fewer than STABLE_CYCLES samples is ignored; a glitch followed by a return to the same pattern does not re-emit.
- On acceptance:
  - Legal digit: ERR=0, BLANK=0, digit event generated.
  - Blank: BLANK=1, ERR=0, no event.
  - Illegal: ERR=1, BLANK=0, no event.
  - In all cases, last-accepted is updated.
- Output FSM, two states:
  - EMPTY: a digit event loads OUT_DIGIT, sets OUT_VALID, increments CHG_CNT → FULL.
  - FULL: OUT_VALID held high and OUT_DIGIT stable until OUT_VALID&&OUT_READY.
    - Handshake with no new event in the same cycle → EMPTY, OUT_VALID=0.
    - Handshake and new event in the same cycle → new digit loaded, CHG_CNT increments, stay FULL (OUT_VALID remains 1).
    - New event with no handshake → event dropped, OVERRUN=1, CHG_CNT unchanged.
- OUT_READY while EMPTY has no effect.
- OVERRUN clears only on rst.
- rst asserted mid-stabilisation or while FULL aborts everything and returns to reset values on that edge; a pending digit is discarded.
- ERR and BLANK are levels reflecting only the most recent acceptance. They do not affect the FSM, and an outstanding digit stays valid.

Decomposition:
- Package seg7_pkg:
  - localparams for the 16 segment codes plus SEG_BLANK=7'h7F.
  - Segment bit-index constants (SEG_A..SEG_G).
  - Output FSM state encoding (ST_EMPTY, ST_FULL).
  - The encoder is to reuse the same constants.
- Sub-module seg7_pattern_decode: combinational; 7-bit pattern → 4-bit digit, is_legal, is_blank. Instantiated once on s_q.

Test Plan:
- STABLE_CYCLES=4, OUT_READY=1; after reset drive SEG=7'h24 → OUT_VALID pulses one cycle after edge n+4 with OUT_DIGIT=2; CHG_CNT=1; ERR=0, BLANK=0.
- Hold 7'h79, insert 7'h24 for 3 cycles, return to 7'h79 → exactly one event (digit 1), no event for 2, CHG_CNT=1.
- OUT_READY=0; present 7'h0E then 7'h46, each held 6 cycles → OUT_DIGIT stays F, OVERRUN=1, CHG_CNT=1; raise OUT_READY → OUT_VALID drops next edge.
- Hold 7'h7F → BLANK=1, no event. Then hold 7'h55 → ERR=1, BLANK=0, no event. Then hold 7'h00 → digit 8 event, ERR=0.
- FULL with digit 3; new 7'h19 acceptance in the same cycle as OUT_READY=1 → OUT_DIGIT=4, OUT_VALID stays 1, CHG_CNT +1, OVERRUN=0.
- Assert rst one cycle while FULL and mid-stabilisation → all outputs at reset values next edge. Same SEG held afterwards → re-accepted after STABLE_CYCLES+1 edges. CHG_CNT wraps 255→0 after 256 alternating legal digits.
